// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector: per-key FSM state
// encoding and the default debounce / long-press windows at 100 MHz.
package key_event_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } key_fsm_state_t;

    localparam int DB_CNT_DEFAULT   = 2000000;
    localparam int LONG_CNT_DEFAULT = 100000000;

endpackage

// File: rtl/key_fsm.sv
// One push-button channel: 2-flop synchronizer, debounce FSM, hold counter.
// Ports: clk, rst (async, active-high), key_in (raw level), key_state,
//   press_pulse, release_pulse, long_pulse (strobes), toggle (level).
// KEY_LONG_PRESS_EN: when defined, long-press counting and long_pulse exist;
//   otherwise long_pulse is tied to 0 and no hold counter is built.
module key_fsm
    import key_event_pkg::*;
#(
    parameter int DB_CNT   = DB_CNT_DEFAULT
`ifdef KEY_LONG_PRESS_EN
    ,
    parameter int LONG_CNT = LONG_CNT_DEFAULT
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_state,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic toggle
);

    localparam int DBW = $clog2(DB_CNT) + 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CNT - 1);

    key_fsm_state_t state;
    logic [DBW-1:0] db_cnt;
    logic           sync_q1;
    logic           sync;
    logic           press_evt;
    logic           release_evt;

    // Debounce window completes this cycle in either direction.
    assign press_evt   = (state == PRESS_DB) && sync && (db_cnt == DB_LAST);
    assign release_evt = (state == RELEASE_DB) && !sync && (db_cnt == DB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1       <= 1'b0;
            sync          <= 1'b0;
            state         <= IDLE;
            db_cnt        <= '0;
            key_state     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            toggle        <= 1'b0;
        end else begin
            sync_q1       <= key_in;
            sync          <= sync_q1;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync) begin
                        state  <= PRESS_DB;
                        db_cnt <= '0;
                    end
                end
                PRESS_DB: begin
                    if (!sync) begin
                        state <= IDLE;
                    end else if (press_evt) begin
                        state       <= HELD;
                        press_pulse <= 1'b1;
                        key_state   <= 1'b1;
                        toggle      <= ~toggle;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!sync) begin
                        state  <= RELEASE_DB;
                        db_cnt <= '0;
                    end
                end
                RELEASE_DB: begin
                    if (sync) begin
                        state <= HELD;
                    end else if (release_evt) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                        key_state     <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEY_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_CNT) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
    localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CNT - 2);

    logic [HW-1:0] hold_cnt;
    logic          holding;

    // The hold keeps running through a release glitch so that a short
    // dropout does not shift the long-press instant.
    assign holding = (state == HELD) || (state == RELEASE_DB);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt   <= '0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (!holding || release_evt) begin
                hold_cnt <= '0;
            end else if (hold_cnt != HOLD_LAST) begin
                hold_cnt   <= hold_cnt + 1'b1;
                long_pulse <= (hold_cnt == HOLD_PRE);
            end
        end
    end
`else
    assign long_pulse = 1'b0;
`endif

endmodule

// File: rtl/key_event_detector.sv
// Debounced multi-key event detector: N_KEYS independent key_fsm channels.
// Ports: clk, rst (async, active-high), key_in[N_KEYS], key_state,
//   press_pulse, release_pulse, long_pulse, toggle (all N_KEYS wide).
// KEY_LONG_PRESS_EN: enables long-press detection; otherwise long_pulse = 0.
module key_event_detector
    import key_event_pkg::*;
#(
    parameter int N_KEYS   = 4,
    parameter int DB_CNT   = DB_CNT_DEFAULT,
    parameter int LONG_CNT = LONG_CNT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_KEYS-1:0] key_in,
    output logic [N_KEYS-1:0] key_state,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse,
    output logic [N_KEYS-1:0] long_pulse,
    output logic [N_KEYS-1:0] toggle
);

    // Elaboration-time parameter sanity checks.
    if (N_KEYS < 1 || N_KEYS > 8) begin : g_bad_nkeys
        $error("key_event_detector: N_KEYS out of range");
    end
    if (DB_CNT < 2) begin : g_bad_db
        $error("key_event_detector: DB_CNT below 2");
    end
    if (LONG_CNT <= DB_CNT) begin : g_bad_long
        $error("key_event_detector: LONG_CNT must exceed DB_CNT");
    end

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        key_fsm #(
            .DB_CNT   (DB_CNT)
`ifdef KEY_LONG_PRESS_EN
            ,
            .LONG_CNT (LONG_CNT)
`endif
        ) u_key (
            .clk           (clk),
            .rst           (rst),
            .key_in        (key_in[i]),
            .key_state     (key_state[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i]),
            .long_pulse    (long_pulse[i]),
            .toggle        (toggle[i])
        );
    end

endmodule

// File: tb/tb_key_event_detector.sv
// Directed scoreboard bench for key_event_detector (N_KEYS=2, DB_CNT=4,
// LONG_CNT=12); expected strobes are queued by cycle and checked each cycle.
module tb_key_event_detector;

`ifdef KEY_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] key_in;
    logic [1:0] key_state;
    logic [1:0] press_pulse;
    logic [1:0] release_pulse;
    logic [1:0] long_pulse;
    logic [1:0] toggle;

    typedef struct {
        int         cyc;
        logic [5:0] val;
    } ev_t;

    ev_t        q[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [1:0] tog = 2'b00;

    key_event_detector #(
        .N_KEYS   (2),
        .DB_CNT   (4),
        .LONG_CNT (12)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .key_in        (key_in),
        .key_state     (key_state),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .toggle        (toggle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h at cycle %0d",
                   tag, obs, exp, cyc);
        end
    endtask

    // dc: cycles from now; p/r/l: press/release/long masks.
    task automatic push(input int dc, input logic [1:0] p,
                        input logic [1:0] r, input logic [1:0] l);
        ev_t e;
        e.cyc = cyc + dc;
        e.val = {p, r, LONG_EN ? l : 2'b00};
        q.push_back(e);
        tog = tog ^ p;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Strobe checker: every cycle the pulses must equal the queued events.
    initial begin
        logic [5:0] exp;
        forever begin
            @(posedge clk);
            #1;
            exp = '0;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    exp |= q[i].val;
                    q.delete(i);
                end
            end
            chk("pulses", {2'b00, press_pulse, release_pulse, long_pulse},
                {2'b00, exp});
        end
    end

    initial begin
        rst    = 1'b1;
        key_in = 2'b00;
        step(3);
        chk("reset_state", {4'h0, key_state, toggle}, 8'h00);
        rst = 1'b0;
        step(2);

        // Clean press then short hold and release.
        key_in[0] = 1'b1;
        push(7, 2'b01, 2'b00, 2'b00);
        step(7);
        chk("clean_state", {6'h0, key_state}, 8'h01);
        chk("clean_toggle", {6'h0, toggle}, {6'h0, tog});
        step(1);
        key_in[0] = 1'b0;
        push(7, 2'b00, 2'b01, 2'b00);
        step(12);
        chk("clean_rel_state", {6'h0, key_state}, 8'h00);

        // Bounce: 3 high, 1 low, 3 high, low.
        key_in[0] = 1'b1;
        step(3);
        key_in[0] = 1'b0;
        step(1);
        key_in[0] = 1'b1;
        step(3);
        key_in[0] = 1'b0;
        step(3);
        chk("bounce_state", {6'h0, key_state}, 8'h00);
        step(10);
        chk("bounce_toggle", {6'h0, toggle}, {6'h0, tog});

        // Long hold of 30 cycles.
        key_in[0] = 1'b1;
        push(7, 2'b01, 2'b00, 2'b00);
        push(18, 2'b00, 2'b00, 2'b01);
        step(30);
        key_in[0] = 1'b0;
        push(7, 2'b00, 2'b01, 2'b00);
        step(12);
        chk("long_rel_state", {6'h0, key_state}, 8'h00);

        // Release glitch while held.
        key_in[0] = 1'b1;
        push(7, 2'b01, 2'b00, 2'b00);
        push(18, 2'b00, 2'b00, 2'b01);
        push(37, 2'b00, 2'b01, 2'b00);
        step(10);
        key_in[0] = 1'b0;
        step(2);
        key_in[0] = 1'b1;
        step(4);
        chk("glitch_state", {6'h0, key_state}, 8'h01);
        step(14);
        key_in[0] = 1'b0;
        step(12);
        chk("glitch_toggle", {6'h0, toggle}, {6'h0, tog});

        // Simultaneous press on both keys.
        key_in = 2'b11;
        push(7, 2'b11, 2'b00, 2'b00);
        step(8);
        chk("simul_state", {6'h0, key_state}, 8'h03);
        step(1);
        key_in = 2'b00;
        push(7, 2'b00, 2'b11, 2'b00);
        step(12);
        chk("simul_toggle", {6'h0, toggle}, {6'h0, tog});
        chk("tog1_first", {7'h0, toggle[1]}, 8'h01);

        // Second round on key 1 only.
        key_in[1] = 1'b1;
        push(7, 2'b10, 2'b00, 2'b00);
        step(9);
        key_in[1] = 1'b0;
        push(7, 2'b00, 2'b10, 2'b00);
        step(12);
        chk("tog1_second", {7'h0, toggle[1]}, 8'h00);

        // Reset while key 0 is in PRESS_DB, key still held.
        key_in[0] = 1'b1;
        step(4);
        rst = 1'b1;
        #1;
        chk("rst_async", {key_state, toggle, press_pulse, release_pulse}, 8'h00);
        step(3);
        chk("rst_hold", {key_state, toggle, press_pulse, long_pulse}, 8'h00);
        tog = 2'b00;
        rst = 1'b0;
        push(7, 2'b01, 2'b00, 2'b00);
        step(6);
        chk("rst_pre_state", {6'h0, key_state}, 8'h00);
        step(2);
        chk("rst_press_state", {6'h0, key_state}, 8'h01);
        chk("rst_toggle", {6'h0, toggle}, {6'h0, tog});
        key_in[0] = 1'b0;
        push(7, 2'b00, 2'b01, 2'b00);
        step(12);

        chk("queue_drained", 8'(q.size()), 8'h00);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/key_event_detector.md
KEY_EVENT_DETECTOR -- requirements
Module: key_event_detector

Interface
- REQ-001: Parameter N_KEYS, default 4: number of independent push-button inputs (1..8).
- REQ-002: Parameter DB_CNT, default 2000000: debounce stability window in clk cycles (20 ms at 100 MHz); legal range 2 and up.
- REQ-003: Parameter LONG_CNT, default 100000000: long-press threshold in clk cycles, counted from press_pulse (1 s at 100 MHz); LONG_CNT > DB_CNT.
- REQ-004: clk  input  1  system clock, 100 MHz.
- REQ-005: rst  input  1  reset, asynchronous, active-high.
- REQ-006: key_in  input  N_KEYS  raw, asynchronous, bouncing button levels; 1 = pressed.
- REQ-007: key_state  output  N_KEYS  debounced level per key.
- REQ-008: press_pulse  output  N_KEYS  one-cycle strobe on a debounced press.
- REQ-009: release_pulse  output  N_KEYS  one-cycle strobe on a debounced release.
- REQ-010: long_pulse  output  N_KEYS  one-cycle strobe when a hold reaches LONG_CNT.
- REQ-011: toggle  output  N_KEYS  level that inverts on every press_pulse (run/pause style control).

Function
- REQ-012: Each key SHALL be handled independently; keys SHALL NOT interact, including simultaneous presses.
- REQ-013: Each key_in bit SHALL pass through a 2-flop synchronizer; only the synchronized value (sync) drives the FSM.
- REQ-014: Per-key FSM states SHALL be IDLE, PRESS_DB, HELD and RELEASE_DB.
- REQ-015: IDLE: sync=1 -> PRESS_DB with debounce counter cleared.
- REQ-016: PRESS_DB: sync=0 -> IDLE with no output. Otherwise the counter increments. At DB_CNT-1 the FSM -> HELD and, in that same transition cycle, press_pulse=1 for one cycle, key_state<=1 and toggle is inverted.
- REQ-017: HELD: the hold counter increments and saturates. When it reaches LONG_CNT-1, long_pulse=1 for exactly one cycle; it SHALL NOT repeat during the same hold. sync=0 -> RELEASE_DB with debounce counter cleared.
- REQ-018: RELEASE_DB: sync=1 -> HELD with the hold counter preserved and no output. At DB_CNT-1 the FSM -> IDLE and release_pulse=1 for one cycle, key_state<=0, hold counter cleared.
- REQ-019: Latency: key_in held stable at 1 from sampling edge t SHALL produce press_pulse in cycle t+DB_CNT+2. Release latency SHALL be identical.
- REQ-020: Any bounce shorter than DB_CNT cycles SHALL produce no pulse and no key_state change.
- REQ-021: Counter widths SHALL be $clog2 of their maximum value plus 1 bit. Counters SHALL NOT wrap.
- REQ-022: press_pulse, release_pulse and long_pulse of one key SHALL be mutually exclusive in any cycle.

Reset
- REQ-023: On rst=1, all FSMs SHALL go to IDLE and all counters and synchronizer flops SHALL be cleared.
- REQ-024: On rst=1, key_state, press_pulse, release_pulse, long_pulse and toggle SHALL be 0.
- REQ-025: Reset asserted mid-press SHALL discard the press. A key still held after rst deasserts SHALL be re-debounced and SHALL produce a fresh press_pulse.

Configuration
- REQ-026: Macro KEY_LONG_PRESS_EN defined: long-press counting and long_pulse SHALL be implemented as in REQ-017.
- REQ-027: Macro KEY_LONG_PRESS_EN undefined: no hold counter SHALL be synthesized and long_pulse SHALL be tied to 0; all other behaviour is unchanged.

Structure
- REQ-028: Shared package key_event_pkg SHALL hold the FSM state encodings (2-bit: IDLE=0, PRESS_DB=1, HELD=2, RELEASE_DB=3) and the default DB_CNT/LONG_CNT constants.
- REQ-029: A sub-module key_fsm (one key: synchronizer, FSM, counters) SHALL be instantiated N_KEYS times by a generate loop.

Verification (bench parameters: N_KEYS=2, DB_CNT=4, LONG_CNT=12)
- REQ-030: Clean press: key_in[0] 0->1 and held -> press_pulse[0] exactly 6 cycles after the first sampling edge, key_state[0]=1, toggle[0]=1, no other pulses.
- REQ-031: Bounce: key_in[0] high 3 cycles, low 1, high 3, low -> no pulse on any output, key_state[0] stays 0.
- REQ-032: Long hold: key_in[0] held 30 cycles -> one press_pulse, then one long_pulse 11 cycles after it, no repeat; release -> release_pulse 6 cycles after key_in falls.
- REQ-033: Release glitch: while HELD, key_in low 2 cycles then high -> no release_pulse, key_state stays 1, long_pulse timing unaffected.
- REQ-034: Simultaneous: both keys pressed in the same cycle -> press_pulse=2'b11 in the same cycle; two full press/release rounds on key 1 -> toggle[1] 0->1->0.
- REQ-035: Mid-press reset: assert rst while key 0 is in PRESS_DB, key still held -> all outputs 0 during reset, then press_pulse[0] DB_CNT+2 cycles after rst deasserts.
